// File: rtl/reg_access_ctrl.sv
// reg_access_ctrl: APB-style register access controller driving one-hot strobes into a field_common register bank
// Optional feature macro: REG_ACCESS_STRB_EN adds pstrb and byte-merged (read-modify-write) writes.
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   psel, penable, pwrite   bus transfer control
//   paddr, pwdata           byte address and write data, latched in the setup cycle
//   pstrb                   byte strobes (only with REG_ACCESS_STRB_EN)
//   prdata                  registered read data
//   pready, pslverr         registered completion and error; withdrawn immediately if psel drops
//   reg_wr_en, reg_wr_data  one-hot write strobe and write word to the bank
//   reg_rd_en               one-hot read strobe for read-clear fields
//   reg_rd_data             register words, register i at [i*DATA_WIDTH +: DATA_WIDTH]
module reg_access_ctrl #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int REG_NUM    = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          psel,
    input  logic                          penable,
    input  logic                          pwrite,
    input  logic [ADDR_WIDTH-1:0]         paddr,
    input  logic [DATA_WIDTH-1:0]         pwdata,
`ifdef REG_ACCESS_STRB_EN
    input  logic [DATA_WIDTH/8-1:0]       pstrb,
`endif
    output logic [DATA_WIDTH-1:0]         prdata,
    output logic                          pready,
    output logic                          pslverr,
    output logic [REG_NUM-1:0]            reg_wr_en,
    output logic [DATA_WIDTH-1:0]         reg_wr_data,
    output logic [REG_NUM-1:0]            reg_rd_en,
    input  logic [REG_NUM*DATA_WIDTH-1:0] reg_rd_data
);
    localparam int IW = ADDR_WIDTH - 2;
    localparam int SW = DATA_WIDTH / 8;

    typedef enum logic [1:0] {IDLE, STROBE, RESP, ERR} state_e;

    state_e                state_q, state_d;
    logic                  wr_q, wr_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] prdata_q, prdata_d;
    logic                  pready_q, pready_d;
    logic                  pslverr_q, pslverr_d;
    logic [REG_NUM-1:0]    wr_en_q, wr_en_d;
    logic [REG_NUM-1:0]    rd_en_q, rd_en_d;
    logic [IW-1:0]         a_idx;
    logic                  a_err;
    logic                  wr_ok;
    logic [REG_NUM-1:0]    one_hot;
    logic [DATA_WIDTH-1:0] rd_word;

    assign a_idx   = paddr[ADDR_WIDTH-1:2];
    assign a_err   = (paddr[1:0] != 2'b00) || (32'(a_idx) >= REG_NUM);
    assign one_hot = REG_NUM'(1) << a_idx;

    always_comb begin
        rd_word = '0;
        for (int i = 0; i < REG_NUM; i++)
            if (idx_q == IW'(i)) rd_word = reg_rd_data[i*DATA_WIDTH +: DATA_WIDTH];
    end

`ifdef REG_ACCESS_STRB_EN
    logic [SW-1:0]         strb_q, strb_d;
    logic [DATA_WIDTH-1:0] merged;

    assign wr_ok = |pstrb;

    // Unstrobed bytes keep the target register's current contents.
    always_comb begin
        merged = rd_word;
        for (int k = 0; k < SW; k++)
            if (strb_q[k]) merged[k*8 +: 8] = wdata_q[k*8 +: 8];
    end

    assign reg_wr_data = (|wr_en_q) ? merged : '0;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) strb_q <= '0;
        else        strb_q <= strb_d;

    always_comb strb_d = (state_q == IDLE && psel && !penable) ? pstrb : strb_q;
`else
    assign wr_ok       = 1'b1;
    assign reg_wr_data = wdata_q;
`endif

    always_comb begin
        state_d   = state_q;
        wr_d      = wr_q;
        idx_d     = idx_q;
        wdata_d   = wdata_q;
        prdata_d  = prdata_q;
        pready_d  = 1'b0;
        pslverr_d = 1'b0;
        wr_en_d   = '0;
        rd_en_d   = '0;
        case (state_q)
            IDLE: if (psel && !penable) begin
                wr_d    = pwrite;
                idx_d   = a_idx;
                wdata_d = pwdata;
                if (a_err) begin
                    state_d   = ERR;
                    pready_d  = 1'b1;
                    pslverr_d = 1'b1;
                    prdata_d  = '0;
                end else begin
                    state_d = STROBE;
                    wr_en_d = (pwrite && wr_ok) ? one_hot : '0;
                    rd_en_d = pwrite ? '0 : one_hot;
                end
            end
            // Read word is captured at the end of the strobe cycle, ahead of any read-clear.
            STROBE: begin
                state_d  = psel ? RESP : IDLE;
                pready_d = psel;
                prdata_d = wr_q ? '0 : rd_word;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            wr_q      <= 1'b0;
            idx_q     <= '0;
            wdata_q   <= '0;
            prdata_q  <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            wr_en_q   <= '0;
            rd_en_q   <= '0;
        end else begin
            state_q   <= state_d;
            wr_q      <= wr_d;
            idx_q     <= idx_d;
            wdata_q   <= wdata_d;
            prdata_q  <= prdata_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
            wr_en_q   <= wr_en_d;
            rd_en_q   <= rd_en_d;
        end
    end

    // A master that withdraws psel mid-transfer never sees a completion.
    assign pready    = pready_q & psel;
    assign pslverr   = pslverr_q & psel;
    assign prdata    = prdata_q;
    assign reg_wr_en = wr_en_q;
    assign reg_rd_en = rd_en_q;
endmodule

// File: tb/tb_reg_access_ctrl.sv
// tb_reg_access_ctrl: scoreboard bench for reg_access_ctrl with a behavioural register-bank model
module tb_reg_access_ctrl;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
    logic [7:0]   paddr = '0;
    logic [31:0]  pwdata = '0;
    logic [3:0]   pstrb = 4'hF;
    logic [31:0]  prdata;
    logic         pready, pslverr;
    logic [15:0]  reg_wr_en, reg_rd_en;
    logic [31:0]  reg_wr_data;
    logic [511:0] reg_rd_data;

    typedef struct { logic [15:0] wr; logic [15:0] rd; logic [31:0] wd; } stb_t;
    typedef struct { logic err; logic chk; logic [31:0] rd; } rsp_t;

    stb_t        stb_q[$];
    rsp_t        rsp_q[$];
    stb_t        mon_st;
    rsp_t        mon_rp;
    logic        prev_stb = 1'b0;
    logic [31:0] bank [16] = '{default: '0};
    logic [31:0] mdl  [16];
    int          total = 0, bad = 0;

    always #5 clk = ~clk;

    reg_access_ctrl dut (
        .clk(clk), .rst_n(rst_n), .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata),
`ifdef REG_ACCESS_STRB_EN
        .pstrb(pstrb),
`endif
        .prdata(prdata), .pready(pready), .pslverr(pslverr),
        .reg_wr_en(reg_wr_en), .reg_wr_data(reg_wr_data), .reg_rd_en(reg_rd_en),
        .reg_rd_data(reg_rd_data)
    );

    // Register bank stand-in: register 1 is read-clear.
    always_comb for (int i = 0; i < 16; i++) reg_rd_data[i*32 +: 32] = bank[i];

    always @(posedge clk)
        for (int i = 0; i < 16; i++)
            if (reg_wr_en[i]) bank[i] <= reg_wr_data;
            else if (reg_rd_en[i] && i == 1) bank[i] <= '0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (|reg_wr_en || |reg_rd_en) begin
            chk("stb_consecutive", 64'(prev_stb), 64'(0));
            if (stb_q.size() == 0) chk("stb_unexpected", 64'({reg_wr_en, reg_rd_en}), 64'(0));
            else begin
                mon_st = stb_q.pop_front();
                chk("stb_wr_en", 64'(reg_wr_en), 64'(mon_st.wr));
                chk("stb_rd_en", 64'(reg_rd_en), 64'(mon_st.rd));
                if (mon_st.wr != 0) chk("stb_wr_data", 64'(reg_wr_data), 64'(mon_st.wd));
            end
        end
        prev_stb <= |reg_wr_en || |reg_rd_en;
    end

    always @(negedge clk)
        if (pready) begin
            if (rsp_q.size() == 0) chk("rsp_unexpected", 64'(pready), 64'(0));
            else begin
                mon_rp = rsp_q.pop_front();
                chk("rsp_pslverr", 64'(pslverr), 64'(mon_rp.err));
                if (mon_rp.chk) chk("rsp_prdata", 64'(prdata), 64'(mon_rp.rd));
            end
        end

    task automatic chk_zero(input string nm);
        chk({nm, "_prdata"}, 64'(prdata), 64'(0));
        chk({nm, "_resp"}, 64'({pready, pslverr}), 64'(0));
        chk({nm, "_strobes"}, 64'({reg_wr_en, reg_rd_en}), 64'(0));
        chk({nm, "_wr_data"}, 64'(reg_wr_data), 64'(0));
    endtask

    // Issues one transfer starting at the current cycle; the model decides the outcome.
    task automatic apb(input logic w, input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
        int idx, lat;
        logic err;
        logic [31:0] m;
        stb_t st;
        rsp_t rp;
`ifndef REG_ACCESS_STRB_EN
        s = 4'hF;
`endif
        idx = int'(a[7:2]);
        err = (a[1:0] != 2'b00) || idx >= 16;
        if (err) rp = '{1'b1, 1'b1, 32'h0};
        else begin
            m = mdl[idx];
            for (int k = 0; k < 4; k++) if (s[k]) m[k*8 +: 8] = d[k*8 +: 8];
            st.wr = (w && s != 0) ? 16'(1) << idx : 16'h0;
            st.rd = w ? 16'h0 : 16'(1) << idx;
            st.wd = m;
            if (st.wr != 0 || st.rd != 0) stb_q.push_back(st);
            rp = w ? '{1'b0, 1'b0, 32'h0} : '{1'b0, 1'b1, mdl[idx]};
            if (w) mdl[idx] = m;
            else if (idx == 1) mdl[1] = '0;
        end
        rsp_q.push_back(rp);
        psel = 1'b1; penable = 1'b0; pwrite = w; paddr = a; pwdata = d; pstrb = s;
        @(posedge clk); #1;
        penable = 1'b1; paddr = 8'($urandom); pwdata = $urandom;
        lat = 1;
        while (!pready && lat < 6) begin
            @(posedge clk); #1;
            lat++;
        end
        chk(err ? "latency_err" : "latency_ok", 64'(lat), err ? 64'(1) : 64'(2));
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog_timeout");
        $fatal(1);
    end

    initial begin
        logic [7:0] a;
        for (int i = 0; i < 16; i++) mdl[i] = '0;
        repeat (3) @(posedge clk);
        #1 chk_zero("reset");
        rst_n = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("idle_strobes", 64'({reg_wr_en, reg_rd_en}), 64'(0));
        end
        @(posedge clk); #1;
        apb(1'b1, 8'h0C, 32'hA5A5_0001, 4'hF);
        apb(1'b1, 8'h04, 32'h1234_5678, 4'hF);
        apb(1'b0, 8'h04, 32'h0, 4'hF);
        apb(1'b0, 8'h04, 32'h0, 4'hF);
        apb(1'b0, 8'h41, 32'h0, 4'hF);
        apb(1'b0, 8'h40, 32'h0, 4'hF);
        apb(1'b1, 8'h40, 32'hFFFF_FFFF, 4'hF);
        apb(1'b1, 8'h00, 32'hCAFE_0042, 4'hF);
        apb(1'b0, 8'h00, 32'h0, 4'hF);
        apb(1'b0, 8'h0C, 32'h0, 4'hF);
        // Reset during the strobe cycle: the write must not land.
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h00; pwdata = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        rst_n = 1'b0; psel = 1'b0;
        #1 chk_zero("reset_mid");
        @(posedge clk); #1;
        chk_zero("reset_hold");
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1 apb(1'b0, 8'h00, 32'h0, 4'hF);
        // Withdrawn psel after the strobe: strobe stands, no completion follows.
        stb_q.push_back('{16'h0, 16'h0004, 32'h0});
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 8'h08;
        @(posedge clk); #1;
        psel = 1'b0;
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b1;
        #1 chk("abort_pready", 64'(pready), 64'(0));
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
`ifdef REG_ACCESS_STRB_EN
        apb(1'b1, 8'h08, 32'h1122_3344, 4'hF);
        apb(1'b1, 8'h08, 32'hAABB_CCDD, 4'b0101);
        apb(1'b0, 8'h08, 32'h0, 4'hF);
        apb(1'b1, 8'h08, 32'h5555_5555, 4'h0);
        apb(1'b0, 8'h08, 32'h0, 4'h0);
`endif
        repeat (60) begin
            a = ($urandom_range(0, 7) == 0) ? 8'($urandom) : {2'b00, 4'($urandom_range(0, 15)), 2'b00};
            apb(1'($urandom), a, $urandom, 4'($urandom));
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
            end
        end
        repeat (3) @(posedge clk);
        #1;
        chk("stb_queue_drained", 64'(stb_q.size()), 64'(0));
        chk("rsp_queue_drained", 64'(rsp_q.size()), 64'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
